// File: rtl/ysyx_22040750_booth_mul_iter_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_22040750_mul_pkg
//   Shared types and constants for the iterative radix-4 Booth multiplier:
//   FSM state encoding, operand signedness encodings, Booth digit values and
//   the digit -> partial-product selector decode.
// -----------------------------------------------------------------------------
package ysyx_22040750_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // sext_flag encodings: [1] = mul1 signed, [0] = mul2 signed.
  localparam logic [1:0] SEXT_UU = 2'b00;  // MULHU / MUL
  localparam logic [1:0] SEXT_SU = 2'b10;  // MULHSU
  localparam logic [1:0] SEXT_SS = 2'b11;  // MULH

  // Radix-4 Booth digits {b(2i+1), b(2i), b(2i-1)}.
  localparam logic [2:0] BOOTH_Z0  = 3'b000;  //  0
  localparam logic [2:0] BOOTH_P1A = 3'b001;  // +1
  localparam logic [2:0] BOOTH_P1B = 3'b010;  // +1
  localparam logic [2:0] BOOTH_P2  = 3'b011;  // +2
  localparam logic [2:0] BOOTH_N2  = 3'b100;  // -2
  localparam logic [2:0] BOOTH_N1A = 3'b101;  // -1
  localparam logic [2:0] BOOTH_N1B = 3'b110;  // -1
  localparam logic [2:0] BOOTH_Z1  = 3'b111;  //  0

  typedef enum logic [2:0] {
    PP_ZERO,
    PP_POS1,
    PP_POS2,
    PP_NEG1,
    PP_NEG2
  } pp_sel_e;

  function automatic pp_sel_e booth_decode(input logic [2:0] digit);
    pp_sel_e sel;
    case (digit)
      BOOTH_P1A, BOOTH_P1B: sel = PP_POS1;
      BOOTH_P2:             sel = PP_POS2;
      BOOTH_N2:             sel = PP_NEG2;
      BOOTH_N1A, BOOTH_N1B: sel = PP_NEG1;
      default:              sel = PP_ZERO;  // BOOTH_Z0, BOOTH_Z1
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ysyx_22040750_booth_mul_iter_if.sv
// -----------------------------------------------------------------------------
// ysyx_22040750_booth_mul_iter_if
//   Operand/result handshake bundle for the iterative Booth multiplier.
//   master : operand producer + product consumer (the EXU side)
//   slave  : the multiplier
//   Signals: in_valid/in_ready/mul1/mul2/sext_flag (operand channel),
//            out_valid/out_ready/out_p (product channel), flush, busy.
// -----------------------------------------------------------------------------
interface ysyx_22040750_booth_mul_iter_if #(
  parameter int W = 64
) ();

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   mul1;
  logic [W-1:0]   mul2;
  logic [1:0]     sext_flag;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;

  modport master (
    output in_valid, mul1, mul2, sext_flag, flush, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, mul1, mul2, sext_flag, flush, out_ready,
    output in_ready, out_valid, out_p, busy
  );

endinterface

// File: rtl/ysyx_22040750_radix4_unit.sv
// -----------------------------------------------------------------------------
// ysyx_22040750_radix4_unit
//   Combinational radix-4 Booth partial-product generator.
//   digit : 3-bit Booth digit {b(2i+1), b(2i), b(2i-1)}
//   mcand : multiplicand, already aligned to the current digit position
//   pp    : 0, +mcand, +2*mcand, or the one's complement of mcand / 2*mcand
//   neg   : +1 carry-in completing the two's-complement negation
// -----------------------------------------------------------------------------
module ysyx_22040750_radix4_unit
  import ysyx_22040750_mul_pkg::*;
#(
  parameter int WIDTH = 132
) (
  input  logic [2:0]       digit,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] pp,
  output logic             neg
);

  logic [WIDTH-1:0] mcand_x2;

  assign mcand_x2 = {mcand[WIDTH-2:0], 1'b0};

  always_comb begin
    // NOTE: every output gets a default first, so no case arm can leave one
    // unassigned and infer a latch.
    pp  = '0;
    neg = 1'b0;
    unique case (booth_decode(digit))
      PP_POS1: pp = mcand;
      PP_POS2: pp = mcand_x2;
      PP_NEG1: begin
        pp  = ~mcand;
        neg = 1'b1;
      end
      PP_NEG2: begin
        pp  = ~mcand_x2;
        neg = 1'b1;
      end
      default: ;  // PP_ZERO keeps the defaults
    endcase
  end

endmodule

// File: rtl/ysyx_22040750_booth_mul_iter.sv
// -----------------------------------------------------------------------------
// ysyx_22040750_booth_mul_iter
//   Iterative radix-4 Booth multiplier: retires two multiplier bits per cycle
//   and produces the full 2W-bit product of mul1 * mul2, each operand signed or
//   unsigned per sext_flag (covers MUL/MULH/MULHSU/MULHU).
//   Ports:
//     clk, rst   clock; synchronous active-high reset
//     bus.slave  in_valid/in_ready/mul1/mul2/sext_flag : operand handshake
//                out_valid/out_ready/out_p              : product handshake
//                flush : abort and drop any operation in flight
//                busy  : state != IDLE
//   Parameters:
//     W           operand width (even, >= 4)
//     EARLY_TERM  finish as soon as every remaining Booth digit is zero
// -----------------------------------------------------------------------------
module ysyx_22040750_booth_mul_iter
  import ysyx_22040750_mul_pkg::*;
#(
  parameter int W          = 64,
  parameter bit EARLY_TERM = 1'b1
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_22040750_booth_mul_iter_if.slave bus
);

  localparam int AW  = 2 * W + 4;          // accumulator / multiplicand width
  localparam int M1W = W + 3;              // multiplier shift register width
  localparam int CW  = $clog2(W / 2 + 2);  // iteration counter width
  localparam logic [CW-1:0] LAST_CNT = CW'(W / 2);

  state_e state, state_next;

  logic [M1W-1:0] m1, m1_next;
  logic [AW-1:0]  m2, acc, acc_next, pp;
  logic           neg;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] out_p;

  logic in_ready, out_valid, busy;
  logic accept, out_fire, last_iter;

  // ---------------------------------------------------------------------------
  // Datapath combinational
  // ---------------------------------------------------------------------------
  ysyx_22040750_radix4_unit #(
    .WIDTH (AW)
  ) u_radix4 (
    .digit (m1[2:0]),
    .mcand (m2),
    .pp    (pp),
    .neg   (neg)
  );

  // Sums wrap modulo 2^AW; the two guard digits above 2W absorb the sign
  // extension, so the low 2W bits are exact for every signedness mix.
  assign acc_next = acc + pp + AW'(neg);
  assign m1_next  = m1 >> 2;

  // Early exit once the shifted-out multiplier holds no non-zero digit:
  // m1_next == 0 makes every remaining digit 3'b000.
  assign last_iter = (cnt == LAST_CNT) || (EARLY_TERM && (m1_next == '0));

  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign out_fire = out_valid && bus.out_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (flush overrides accept and the out handshake)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept)    state_next = BUSY;
        BUSY:    if (last_iter) state_next = DONE;
        DONE:    if (out_fire)  state_next = IDLE;
        default:                state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (all decoded from the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      m1    <= '0;
      m2    <= '0;
      acc   <= '0;
      cnt   <= '0;
      out_p <= '0;
    end else if (accept) begin
      // Two copies of the multiplier sign give W/2+1 digits, enough to cover
      // an unsigned W-bit operand; the trailing 0 is b(-1).
      m1  <= {{2{bus.mul1[W-1] & bus.sext_flag[1]}}, bus.mul1, 1'b0};
      m2  <= {{(W + 4){bus.mul2[W-1] & bus.sext_flag[0]}}, bus.mul2};
      acc <= '0;
      cnt <= '0;
    end else if ((state == BUSY) && !bus.flush) begin
      m1  <= m1_next;
      m2  <= m2 << 2;
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (last_iter) out_p <= acc_next[2*W-1:0];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.out_p     = out_p;

endmodule
